// File: rtl/chess_clock_ctrl.sv
// -----------------------------------------------------------------------------
// chess_clock_ctrl
//
// Two-player chess clock controller. Sequences a new game (timer reset, then a
// settling window), decides which of the two countdown timers runs, hands the
// clock over on qualified move presses, handles pause/resume, and converts the
// active player's time_up flag into a game-over verdict.
//
// Ports
//   clk            in   system clock, sole clock domain
//   reset_n        in   asynchronous active-low reset
//   new_game       in   single-cycle pulse, starts a new game (highest priority)
//   mode_sel[1:0]  in   time-control selection, captured on new_game
//   move_btn       in   level; rising edge = current player finished a move
//   pause_btn      in   level; rising edge toggles pause
//   white_time_up  in   level from white timer, high at zero
//   black_time_up  in   level from black timer, high at zero
//   counter_rst_n  out  active-low reset to both timers
//   mode_latched   out  mode_sel captured on new_game
//   white_run      out  white timer run enable
//   black_run      out  black timer run enable
//   active_player  out  0 = white to move, 1 = black to move
//   paused         out  high while paused
//   game_over      out  high once a flag has fallen
//   winner[1:0]    out  00 none, 01 white, 10 black
//   move_count     out  completed half-moves, saturating at 1023
//   dbg_state      out  current FSM state encoding (for checkers)
//
// Handshake: there is no valid/ready pair here. new_game is a one-cycle
// strobe; move_btn and pause_btn are levels whose rising edges are events;
// every output is a flop that changes on the clk edge after its cause.
// -----------------------------------------------------------------------------
module chess_clock_ctrl #(
   parameter int CLK_FREQ_HZ     = 50_000_000,
   parameter int MOVE_LOCKOUT_MS = 200
) (
   input  logic       clk,
   input  logic       reset_n,
   input  logic       new_game,
   input  logic [1:0] mode_sel,
   input  logic       move_btn,
   input  logic       pause_btn,
   input  logic       white_time_up,
   input  logic       black_time_up,
   output logic       counter_rst_n,
   output logic [1:0] mode_latched,
   output logic       white_run,
   output logic       black_run,
   output logic       active_player,
   output logic       paused,
   output logic       game_over,
   output logic [1:0] winner,
   output logic [9:0] move_count,
   output logic [2:0] dbg_state
);

   localparam int LOCKOUT_CYCLES = CLK_FREQ_HZ / 1000 * MOVE_LOCKOUT_MS;
   localparam int LW = (LOCKOUT_CYCLES > 0) ? $clog2(LOCKOUT_CYCLES + 1) : 1;
   localparam logic [LW-1:0] LOCK_LOAD = LW'(LOCKOUT_CYCLES);

   typedef enum logic [2:0] {
      S_IDLE      = 3'd0,
      S_CLEAR     = 3'd1,
      S_ARMED     = 3'd2,
      S_WHITE_RUN = 3'd3,
      S_BLACK_RUN = 3'd4,
      S_PAUSED    = 3'd5,
      S_OVER      = 3'd6
   } state_t;

   state_t        state_q, state_d;
   logic          phase_q, phase_d;        // second-cycle marker in CLEAR/ARMED
   logic [LW-1:0] lock_q, lock_d;
   logic          move_prev_q, pause_prev_q;

   logic          counter_rst_n_q, counter_rst_n_d;
   logic [1:0]    mode_latched_q, mode_latched_d;
   logic          white_run_q, white_run_d;
   logic          black_run_q, black_run_d;
   logic          active_player_q, active_player_d;
   logic          paused_q, paused_d;
   logic          game_over_q, game_over_d;
   logic [1:0]    winner_q, winner_d;
   logic [9:0]    move_count_q, move_count_d;

   logic          move_edge, pause_edge, move_ok;
   logic [9:0]    move_count_inc;

   always_comb begin
      move_edge      = move_btn & ~move_prev_q;
      pause_edge     = pause_btn & ~pause_prev_q;
      move_ok        = move_edge && (lock_q == '0);
      move_count_inc = (move_count_q == 10'h3FF) ? move_count_q : move_count_q + 10'd1;

      state_d         = state_q;
      phase_d         = 1'b0;
      // Lockout free-runs down to zero in every state, including PAUSED.
      lock_d          = (lock_q != '0) ? lock_q - 1'b1 : lock_q;
      mode_latched_d  = mode_latched_q;
      active_player_d = active_player_q;
      winner_d        = winner_q;
      move_count_d    = move_count_q;

      if (new_game) begin
         // Re-entering CLEAR from anywhere restarts the two-cycle timer reset.
         state_d         = S_CLEAR;
         lock_d          = '0;
         mode_latched_d  = mode_sel;
         move_count_d    = '0;
         winner_d        = 2'b00;
         active_player_d = 1'b0;
      end else begin
         case (state_q)
            S_IDLE: ;
            S_CLEAR: begin
               if (!phase_q) phase_d = 1'b1;
               else          state_d = S_ARMED;
            end
            S_ARMED: begin
               // time_up inputs are ignored: timers read zero while leaving reset.
               if (!phase_q) phase_d = 1'b1;
               else          state_d = S_WHITE_RUN;
            end
            S_WHITE_RUN: begin
               if (white_time_up) begin
                  state_d  = S_OVER;
                  winner_d = 2'b10;
               end else if (move_ok) begin
                  state_d         = S_BLACK_RUN;
                  active_player_d = 1'b1;
                  move_count_d    = move_count_inc;
                  lock_d          = LOCK_LOAD;
               end else if (pause_edge) begin
                  state_d = S_PAUSED;
               end
            end
            S_BLACK_RUN: begin
               if (black_time_up) begin
                  state_d  = S_OVER;
                  winner_d = 2'b01;
               end else if (move_ok) begin
                  state_d         = S_WHITE_RUN;
                  active_player_d = 1'b0;
                  move_count_d    = move_count_inc;
                  lock_d          = LOCK_LOAD;
               end else if (pause_edge) begin
                  state_d = S_PAUSED;
               end
            end
            S_PAUSED: begin
               if (pause_edge) state_d = active_player_q ? S_BLACK_RUN : S_WHITE_RUN;
            end
            S_OVER: ;
            default: state_d = S_IDLE;
         endcase
      end

      // Outputs are decoded from the next state so they are registered yet
      // change on the same edge as the state itself.
      counter_rst_n_d = !((state_d == S_IDLE) || (state_d == S_CLEAR));
      white_run_d     = (state_d == S_WHITE_RUN);
      black_run_d     = (state_d == S_BLACK_RUN);
      paused_d        = (state_d == S_PAUSED);
      game_over_d     = (state_d == S_OVER);
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q         <= S_IDLE;
         phase_q         <= 1'b0;
         lock_q          <= '0;
         move_prev_q     <= 1'b0;
         pause_prev_q    <= 1'b0;
         counter_rst_n_q <= 1'b0;
         mode_latched_q  <= 2'b00;
         white_run_q     <= 1'b0;
         black_run_q     <= 1'b0;
         active_player_q <= 1'b0;
         paused_q        <= 1'b0;
         game_over_q     <= 1'b0;
         winner_q        <= 2'b00;
         move_count_q    <= '0;
      end else begin
         state_q         <= state_d;
         phase_q         <= phase_d;
         lock_q          <= lock_d;
         move_prev_q     <= move_btn;
         pause_prev_q    <= pause_btn;
         counter_rst_n_q <= counter_rst_n_d;
         mode_latched_q  <= mode_latched_d;
         white_run_q     <= white_run_d;
         black_run_q     <= black_run_d;
         active_player_q <= active_player_d;
         paused_q        <= paused_d;
         game_over_q     <= game_over_d;
         winner_q        <= winner_d;
         move_count_q    <= move_count_d;
      end
   end

   assign counter_rst_n = counter_rst_n_q;
   assign mode_latched  = mode_latched_q;
   assign white_run     = white_run_q;
   assign black_run     = black_run_q;
   assign active_player = active_player_q;
   assign paused        = paused_q;
   assign game_over     = game_over_q;
   assign winner        = winner_q;
   assign move_count    = move_count_q;
   assign dbg_state     = state_q;

endmodule

// File: tb/tb_chess_clock_ctrl.sv
// -----------------------------------------------------------------------------
// tb_chess_clock_ctrl
//
// Bench for chess_clock_ctrl with a 10-cycle move lockout. Expected output
// vectors {white_run, black_run, active_player, paused, game_over, winner,
// move_count, counter_rst_n, mode_latched} are pushed to exp_q as stimulus is
// driven and popped when the DUT output for that cycle is sampled (#1 after
// the active edge).
// -----------------------------------------------------------------------------
module tb_chess_clock_ctrl;

   localparam int W = 20;

   logic       clk = 1'b0;
   logic       reset_n;
   logic       new_game;
   logic [1:0] mode_sel;
   logic       move_btn;
   logic       pause_btn;
   logic       white_time_up;
   logic       black_time_up;
   logic       counter_rst_n;
   logic [1:0] mode_latched;
   logic       white_run;
   logic       black_run;
   logic       active_player;
   logic       paused;
   logic       game_over;
   logic [1:0] winner;
   logic [9:0] move_count;
   logic [2:0] dbg_state;

   logic [W-1:0] exp_q[$];
   logic [W-1:0] exp_v, obs_v;
   int checks = 0;
   int errors = 0;

   chess_clock_ctrl #(
      .CLK_FREQ_HZ     (1000),
      .MOVE_LOCKOUT_MS (10)
   ) dut (
      .clk           (clk),
      .reset_n       (reset_n),
      .new_game      (new_game),
      .mode_sel      (mode_sel),
      .move_btn      (move_btn),
      .pause_btn     (pause_btn),
      .white_time_up (white_time_up),
      .black_time_up (black_time_up),
      .counter_rst_n (counter_rst_n),
      .mode_latched  (mode_latched),
      .white_run     (white_run),
      .black_run     (black_run),
      .active_player (active_player),
      .paused        (paused),
      .game_over     (game_over),
      .winner        (winner),
      .move_count    (move_count),
      .dbg_state     (dbg_state)
   );

   // ---------------- clock / watchdog ----------------
   always #5 clk = ~clk;

   initial begin
      #1_000_000;
      $display("FAIL watchdog got timeout expected finish");
      $fatal(1, "watchdog");
   end

   // ---------------- helpers ----------------
   function automatic logic [W-1:0] mk(input logic wr, input logic br, input logic ap,
                                       input logic pa, input logic go, input logic [1:0] win,
                                       input logic [9:0] mc, input logic crn, input logic [1:0] ml);
      return {wr, br, ap, pa, go, win, mc, crn, ml};
   endfunction

   function automatic logic [W-1:0] pack_obs();
      return {white_run, black_run, active_player, paused, game_over, winner,
              move_count, counter_rst_n, mode_latched};
   endfunction

   // Advance one clock; afterwards inputs set belong to the next cycle.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_cycles(input int n);
      for (int i = 0; i < n; i++) step();
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      reset_n = 1'b0; new_game = 1'b0; mode_sel = 2'b00; move_btn = 1'b0;
      pause_btn = 1'b0; white_time_up = 1'b0; black_time_up = 1'b0;
      exp_q.push_back(mk(0, 0, 0, 0, 0, 2'b00, 10'd0, 0, 2'b00));
      wait_cycles(3);
      reset_n = 1'b1;
      step();
      obs_v = pack_obs(); exp_v = exp_q.pop_front(); checks++;
      if (obs_v !== exp_v) begin errors++; $display("FAIL reset_values got %h expected %h", obs_v, exp_v); end
      checks++;
      if (dbg_state !== 3'd0) begin errors++; $display("FAIL reset_state got %0d expected 0", dbg_state); end
   endtask

   task automatic test_new_game();
      new_game = 1'b1; mode_sel = 2'b10;
      exp_q.push_back(mk(0, 0, 0, 0, 0, 2'b00, 10'd0, 0, 2'b10));
      step();  // T+1
      new_game = 1'b0; mode_sel = 2'b01;
      obs_v = pack_obs(); exp_v = exp_q.pop_front(); checks++;
      if (obs_v !== exp_v) begin errors++; $display("FAIL newgame_t1 got %h expected %h", obs_v, exp_v); end
      exp_q.push_back(mk(0, 0, 0, 0, 0, 2'b00, 10'd0, 0, 2'b10));
      step();  // T+2
      obs_v = pack_obs(); exp_v = exp_q.pop_front(); checks++;
      if (obs_v !== exp_v) begin errors++; $display("FAIL newgame_t2 got %h expected %h", obs_v, exp_v); end
      exp_q.push_back(mk(0, 0, 0, 0, 0, 2'b00, 10'd0, 1, 2'b10));
      step();  // T+3, ARMED
      white_time_up = 1'b1;
      obs_v = pack_obs(); exp_v = exp_q.pop_front(); checks++;
      if (obs_v !== exp_v) begin errors++; $display("FAIL newgame_t3 got %h expected %h", obs_v, exp_v); end
      checks++;
      if (dbg_state !== 3'd2) begin errors++; $display("FAIL armed_state got %0d expected 2", dbg_state); end
      exp_q.push_back(mk(0, 0, 0, 0, 0, 2'b00, 10'd0, 1, 2'b10));
      step();  // T+4, flag sampled in ARMED is ignored
      obs_v = pack_obs(); exp_v = exp_q.pop_front(); checks++;
      if (obs_v !== exp_v) begin errors++; $display("FAIL newgame_t4 got %h expected %h", obs_v, exp_v); end
      exp_q.push_back(mk(1, 0, 0, 0, 0, 2'b00, 10'd0, 1, 2'b10));
      step();  // T+5
      white_time_up = 1'b0;
      obs_v = pack_obs(); exp_v = exp_q.pop_front(); checks++;
      if (obs_v !== exp_v) begin errors++; $display("FAIL newgame_t5 got %h expected %h", obs_v, exp_v); end
   endtask

   task automatic test_handoff();
      move_btn = 1'b1;  // cycle A
      exp_q.push_back(mk(0, 1, 1, 0, 0, 2'b00, 10'd1, 1, 2'b10));
      step();  // A+1
      move_btn = 1'b0;
      obs_v = pack_obs(); exp_v = exp_q.pop_front(); checks++;
      if (obs_v !== exp_v) begin errors++; $display("FAIL handoff_first got %h expected %h", obs_v, exp_v); end
      wait_cycles(4);  // A+5
      move_btn = 1'b1;
      exp_q.push_back(mk(0, 1, 1, 0, 0, 2'b00, 10'd1, 1, 2'b10));
      step();  // A+6
      move_btn = 1'b0;
      obs_v = pack_obs(); exp_v = exp_q.pop_front(); checks++;
      if (obs_v !== exp_v) begin errors++; $display("FAIL lockout_drop got %h expected %h", obs_v, exp_v); end
      wait_cycles(6);  // A+12
      move_btn = 1'b1;
      exp_q.push_back(mk(1, 0, 0, 0, 0, 2'b00, 10'd2, 1, 2'b10));
      step();  // A+13
      move_btn = 1'b0;
      obs_v = pack_obs(); exp_v = exp_q.pop_front(); checks++;
      if (obs_v !== exp_v) begin errors++; $display("FAIL handoff_second got %h expected %h", obs_v, exp_v); end
   endtask

   task automatic test_pause();
      wait_cycles(11);
      move_btn = 1'b1;
      exp_q.push_back(mk(0, 1, 1, 0, 0, 2'b00, 10'd3, 1, 2'b10));
      step();
      move_btn = 1'b0;
      obs_v = pack_obs(); exp_v = exp_q.pop_front(); checks++;
      if (obs_v !== exp_v) begin errors++; $display("FAIL pause_setup got %h expected %h", obs_v, exp_v); end
      pause_btn = 1'b1;
      exp_q.push_back(mk(0, 0, 1, 1, 0, 2'b00, 10'd3, 1, 2'b10));
      step();
      pause_btn = 1'b0;
      obs_v = pack_obs(); exp_v = exp_q.pop_front(); checks++;
      if (obs_v !== exp_v) begin errors++; $display("FAIL pause_enter got %h expected %h", obs_v, exp_v); end
      wait_cycles(12);  // lockout expires while paused
      move_btn = 1'b1; black_time_up = 1'b1;
      exp_q.push_back(mk(0, 0, 1, 1, 0, 2'b00, 10'd3, 1, 2'b10));
      step();
      move_btn = 1'b0; black_time_up = 1'b0;
      obs_v = pack_obs(); exp_v = exp_q.pop_front(); checks++;
      if (obs_v !== exp_v) begin errors++; $display("FAIL pause_ignore got %h expected %h", obs_v, exp_v); end
      step();
      pause_btn = 1'b1;
      exp_q.push_back(mk(0, 1, 1, 0, 0, 2'b00, 10'd3, 1, 2'b10));
      step();
      pause_btn = 1'b0;
      obs_v = pack_obs(); exp_v = exp_q.pop_front(); checks++;
      if (obs_v !== exp_v) begin errors++; $display("FAIL pause_resume got %h expected %h", obs_v, exp_v); end
   endtask

   task automatic test_flag_collision();
      move_btn = 1'b1;
      exp_q.push_back(mk(1, 0, 0, 0, 0, 2'b00, 10'd4, 1, 2'b10));
      step();
      move_btn = 1'b0;
      obs_v = pack_obs(); exp_v = exp_q.pop_front(); checks++;
      if (obs_v !== exp_v) begin errors++; $display("FAIL flag_setup got %h expected %h", obs_v, exp_v); end
      black_time_up = 1'b1;
      exp_q.push_back(mk(1, 0, 0, 0, 0, 2'b00, 10'd4, 1, 2'b10));
      step();
      black_time_up = 1'b0;
      obs_v = pack_obs(); exp_v = exp_q.pop_front(); checks++;
      if (obs_v !== exp_v) begin errors++; $display("FAIL inactive_flag got %h expected %h", obs_v, exp_v); end
      wait_cycles(12);
      white_time_up = 1'b1; move_btn = 1'b1;
      exp_q.push_back(mk(0, 0, 0, 0, 1, 2'b10, 10'd4, 1, 2'b10));
      step();
      white_time_up = 1'b0; move_btn = 1'b0;
      obs_v = pack_obs(); exp_v = exp_q.pop_front(); checks++;
      if (obs_v !== exp_v) begin errors++; $display("FAIL flag_vs_move got %h expected %h", obs_v, exp_v); end
      step();
      pause_btn = 1'b1;
      exp_q.push_back(mk(0, 0, 0, 0, 1, 2'b10, 10'd4, 1, 2'b10));
      step();
      pause_btn = 1'b0;
      obs_v = pack_obs(); exp_v = exp_q.pop_front(); checks++;
      if (obs_v !== exp_v) begin errors++; $display("FAIL over_hold got %h expected %h", obs_v, exp_v); end
   endtask

   task automatic test_saturation();
      logic [9:0] m_mc;
      logic       m_ap;
      new_game = 1'b1; mode_sel = 2'b01;
      exp_q.push_back(mk(0, 0, 0, 0, 0, 2'b00, 10'd0, 0, 2'b01));
      step();
      new_game = 1'b0;
      obs_v = pack_obs(); exp_v = exp_q.pop_front(); checks++;
      if (obs_v !== exp_v) begin errors++; $display("FAIL restart_clear got %h expected %h", obs_v, exp_v); end
      wait_cycles(4);
      m_mc = 10'd0; m_ap = 1'b0;
      for (int i = 0; i < 1030; i++) begin
         move_btn = 1'b1;
         m_mc = (m_mc == 10'd1023) ? m_mc : m_mc + 10'd1;
         m_ap = ~m_ap;
         exp_q.push_back(mk(~m_ap, m_ap, m_ap, 0, 0, 2'b00, m_mc, 1, 2'b01));
         step();
         move_btn = 1'b0;
         obs_v = pack_obs(); exp_v = exp_q.pop_front(); checks++;
         if (obs_v !== exp_v) begin errors++; $display("FAIL sat_move_%0d got %h expected %h", i, obs_v, exp_v); end
         wait_cycles(11 + $urandom_range(0, 2));
      end
      // 1030 moves is even: white to move
      white_time_up = 1'b1;
      exp_q.push_back(mk(0, 0, 0, 0, 1, 2'b10, 10'd1023, 1, 2'b01));
      step();
      white_time_up = 1'b0;
      obs_v = pack_obs(); exp_v = exp_q.pop_front(); checks++;
      if (obs_v !== exp_v) begin errors++; $display("FAIL sat_over got %h expected %h", obs_v, exp_v); end
      new_game = 1'b1; mode_sel = 2'b11;
      exp_q.push_back(mk(0, 0, 0, 0, 0, 2'b00, 10'd0, 0, 2'b11));
      step();
      new_game = 1'b0;
      obs_v = pack_obs(); exp_v = exp_q.pop_front(); checks++;
      if (obs_v !== exp_v) begin errors++; $display("FAIL over_restart got %h expected %h", obs_v, exp_v); end
   endtask

   task automatic test_async_reset();
      wait_cycles(4);  // WHITE_RUN
      move_btn = 1'b1;
      exp_q.push_back(mk(0, 1, 1, 0, 0, 2'b00, 10'd1, 1, 2'b11));
      step();
      move_btn = 1'b0;
      obs_v = pack_obs(); exp_v = exp_q.pop_front(); checks++;
      if (obs_v !== exp_v) begin errors++; $display("FAIL areset_setup got %h expected %h", obs_v, exp_v); end
      #2;
      reset_n = 1'b0;
      exp_q.push_back(mk(0, 0, 0, 0, 0, 2'b00, 10'd0, 0, 2'b00));
      #1;
      obs_v = pack_obs(); exp_v = exp_q.pop_front(); checks++;
      if (obs_v !== exp_v) begin errors++; $display("FAIL areset_values got %h expected %h", obs_v, exp_v); end
      checks++;
      if (dbg_state !== 3'd0) begin errors++; $display("FAIL areset_state got %0d expected 0", dbg_state); end
      step();
      reset_n = 1'b1;
      step();
   endtask

   task automatic test_back_to_back();
      new_game = 1'b1; mode_sel = 2'b11;
      exp_q.push_back(mk(0, 0, 0, 0, 0, 2'b00, 10'd0, 0, 2'b11));
      step();  // T+1, second new_game restarts CLEAR
      mode_sel = 2'b01;
      obs_v = pack_obs(); exp_v = exp_q.pop_front(); checks++;
      if (obs_v !== exp_v) begin errors++; $display("FAIL b2b_t1 got %h expected %h", obs_v, exp_v); end
      exp_q.push_back(mk(0, 0, 0, 0, 0, 2'b00, 10'd0, 0, 2'b01));
      step();  // T+2
      new_game = 1'b0;
      obs_v = pack_obs(); exp_v = exp_q.pop_front(); checks++;
      if (obs_v !== exp_v) begin errors++; $display("FAIL b2b_t2 got %h expected %h", obs_v, exp_v); end
      exp_q.push_back(mk(0, 0, 0, 0, 0, 2'b00, 10'd0, 0, 2'b01));
      step();  // T+3, still CLEAR
      obs_v = pack_obs(); exp_v = exp_q.pop_front(); checks++;
      if (obs_v !== exp_v) begin errors++; $display("FAIL b2b_t3 got %h expected %h", obs_v, exp_v); end
      step();  // T+4
      exp_q.push_back(mk(0, 0, 0, 0, 0, 2'b00, 10'd0, 1, 2'b01));
      step();  // T+5, ARMED
      obs_v = pack_obs(); exp_v = exp_q.pop_front(); checks++;
      if (obs_v !== exp_v) begin errors++; $display("FAIL b2b_t5 got %h expected %h", obs_v, exp_v); end
      exp_q.push_back(mk(1, 0, 0, 0, 0, 2'b00, 10'd0, 1, 2'b01));
      step();  // T+6
      obs_v = pack_obs(); exp_v = exp_q.pop_front(); checks++;
      if (obs_v !== exp_v) begin errors++; $display("FAIL b2b_t6 got %h expected %h", obs_v, exp_v); end
   endtask

   // ---------------- sequence + report ----------------
   initial begin
      test_reset();
      test_new_game();
      test_handoff();
      test_pause();
      test_flag_collision();
      test_saturation();
      test_async_reset();
      test_back_to_back();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/chess_clock_ctrl.md
# chess_clock_ctrl

Two-player chess clock controller that drives the per-player countdown timers on the game-play path. It sequences a new game, decides which player's timer runs, and handles move hand-off, pause/resume and flag detection. It turns the timers' `time_up` flags into a game-over verdict. It sits between the game logic (new game, move, pause) and the two timer instances (white, black), which share its reset and mode outputs.

## Interface
- `CLK_FREQ_HZ`, 50_000_000, system clock frequency.
- `MOVE_LOCKOUT_MS`, 200, window after each clock hand-off in which move presses are ignored; `LOCKOUT_CYCLES = CLK_FREQ_HZ/1000*MOVE_LOCKOUT_MS`.

- `clk`  in  1  system clock; sole clock domain.
- `reset_n`  in  1  asynchronous active-low reset.
- `new_game`  in  1  synchronous single-cycle pulse; starts a new game.
- `mode_sel`  in  2  time-control selection; sampled only on `new_game`.
- `move_btn`  in  1  synchronous level; a rising edge means the current player has completed a move.
- `pause_btn`  in  1  synchronous level; a rising edge toggles pause.
- `white_time_up`, `black_time_up`  in  1 each  level from each timer; high when that timer reads zero.
- `counter_rst_n`  out  1  active-low reset to both timers.
- `mode_latched`  out  2  `mode_sel` captured on `new_game`.
- `white_run`, `black_run`  out  1 each  run enables; at most one is high.
- `active_player`  out  1  0 = white to move, 1 = black to move.
- `paused`  out  1  high in PAUSED.
- `game_over`  out  1  high in OVER.
- `winner`  out  2  00 none, 01 white, 10 black.
- `move_count`  out  10  number of half-moves completed; saturates at 1023.

## Operation
- States: IDLE, CLEAR, ARMED, WHITE_RUN, BLACK_RUN, PAUSED, OVER.
- IDLE:
  - `counter_rst_n`=0 and both run enables are 0.
  - `new_game` → CLEAR.
- CLEAR:
  - Lasts exactly 2 cycles with `counter_rst_n`=0.
  - On entry: latch `mode_latched`, clear `move_count`, `winner` and `active_player`.
  - Then → ARMED.
- ARMED:
  - Lasts exactly 2 cycles with `counter_rst_n`=1 and run enables at 0.
  - Both `time_up` inputs are ignored here, because timers report zero while leaving reset.
  - Then → WHITE_RUN.
- WHITE_RUN:
  - `white_run`=1 and `active_player`=0.
  - If `white_time_up`=1 → OVER with `winner`=10.
  - Otherwise, on a qualified move edge → BLACK_RUN, `move_count`+1, lockout reloaded.
  - Otherwise, on a pause edge → PAUSED.
- BLACK_RUN: mirror of WHITE_RUN. Flag gives `winner`=01; a qualified move → WHITE_RUN.
- PAUSED:
  - Both run enables are 0. `active_player` holds its value; move edges and both `time_up` inputs are ignored.
  - A pause edge → the RUN state given by `active_player`.
- OVER: run enables are 0 and `game_over`=1. Only `new_game` exits.
- Priority in every state: `new_game` (→ CLEAR, restarting the CLEAR timing) > flag > move > pause.
- The `time_up` of the inactive player is ignored in all states.
- Edge detection: each button has a previous-value register, reset to 0. An edge is `btn & ~prev`.
- Lockout counter:
  - Loaded with `LOCKOUT_CYCLES` on each hand-off, then decrements to 0.
  - A move edge qualifies only when the counter is 0.
  - Edges that arrive during lockout are dropped, not queued.
  - The counter keeps running in PAUSED. It is cleared in CLEAR.
- `move_count` saturates at 1023 and never wraps.

## Timing
- Reset values: state IDLE, `counter_rst_n`=0, `mode_latched`=00, both run enables 0, `active_player`=0, `paused`=0, `game_over`=0, `winner`=00, `move_count`=0, lockout counter 0.
- All outputs are registered and change on the clk edge after the causing input.
- `new_game` in cycle T:
  - `counter_rst_n` is low in T+1 and T+2.
  - ARMED occupies T+3 and T+4.
  - `white_run`=1 from T+5.
- A move edge sampled in cycle T: run enables swap and `move_count` updates at T+1.
- A flag sampled in cycle T: run enables drop and `game_over`=1 at T+1.
- Reset mid-game: asynchronous return to the reset values.

## Test plan
Simulation parameters: `CLK_FREQ_HZ`=1000 and `MOVE_LOCKOUT_MS`=10, giving `LOCKOUT_CYCLES`=10.
- New-game sequencing: `new_game` at T with `mode_sel`=10 → `counter_rst_n` low at T+1 and T+2, `white_run`=1 at T+5, `mode_latched`=10; `white_time_up`=1 during T+3 and T+4 is ignored.
- Hand-off and lockout: move edge → `black_run`=1 and `move_count`=1; a second edge 5 cycles later is ignored; an edge at +12 cycles → `white_run`=1 and `move_count`=2.
- Pause/resume: in BLACK_RUN, pause edge → both run enables 0 and `paused`=1; move edge and `black_time_up` pulse are ignored; pause edge → `black_run`=1 again.
- Flag vs. move collision: in WHITE_RUN, `white_time_up` and a move edge in the same cycle → OVER, `winner`=10, `move_count` unchanged; `black_time_up` alone in WHITE_RUN → no effect.
- Saturation and restart: drive 1030 qualified moves → `move_count`=1023; `new_game` from OVER → `move_count`=0, `winner`=00, `game_over`=0 at T+1.
- Async reset: assert `reset_n` low in BLACK_RUN mid-cycle → all outputs take their reset values immediately, without waiting for a clk edge.
